// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers for the pipelined adder tree: level count, result width
// and the number of partial sums alive at each tree level.
package adder_tree_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // A single lane still gets one register stage, so depth never drops to zero.
  function automatic int calc_lvls(input int num_in);
    return (clog2(num_in) < 1) ? 1 : clog2(num_in);
  endfunction

  function automatic int calc_out_w(input int data_w, input int num_in);
    return data_w + clog2(num_in);
  endfunction

  function automatic int elem_cnt(input int num_in, input int lvl);
    return (num_in + (1 << lvl) - 1) >> lvl;
  endfunction

endpackage

// File: rtl/pipelined_adder_tree_if.sv
// Valid/ready bus of the adder tree; sat_out exists only when ADDER_TREE_SAT_EN
// is defined. master = upstream/downstream side, slave = the tree itself.
interface pipelined_adder_tree_if
  import adder_tree_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 4
);
  localparam int OUT_W = calc_out_w(DATA_W, NUM_IN);

  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W*NUM_IN-1:0] data_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         data_out;
`ifdef ADDER_TREE_SAT_EN
  logic                     sat_out;

  modport master (output in_valid, data_in, out_ready,
                  input  in_ready, out_valid, data_out, sat_out);
  modport slave  (input  in_valid, data_in, out_ready,
                  output in_ready, out_valid, data_out, sat_out);
`else
  modport master (output in_valid, data_in, out_ready,
                  input  in_ready, out_valid, data_out);
  modport slave  (input  in_valid, data_in, out_ready,
                  output in_ready, out_valid, data_out);
`endif
endinterface

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: pairwise adds with one bit of growth,
// odd leftover element passes through extended.
module adder_tree_level #(
  parameter int IN_W   = 32,
  parameter int IN_CNT = 4,
  parameter int SIGNED = 1,
  localparam int OUT_CNT = (IN_CNT + 1) / 2,
  localparam int OUT_W   = IN_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv,
  input  logic                     in_vld,
  input  logic [IN_CNT*IN_W-1:0]   in_vec,
  output logic                     out_vld,
  output logic [OUT_CNT*OUT_W-1:0] out_vec
);

  logic [OUT_CNT*OUT_W-1:0] sum_w;
  logic [OUT_CNT*OUT_W-1:0] vec_d, vec_q;
  logic                     vld_d, vld_q;

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] x);
    return {(SIGNED != 0) ? x[IN_W-1] : 1'b0, x};
  endfunction

  for (genvar j = 0; j < OUT_CNT; j++) begin : g_elem
    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_ext;
    assign a_ext = extend(in_vec[2*j*IN_W +: IN_W]);
    if (2*j + 1 < IN_CNT) begin : g_pair
      assign b_ext = extend(in_vec[(2*j+1)*IN_W +: IN_W]);
    end else begin : g_odd
      assign b_ext = '0;
    end
    assign sum_w[j*OUT_W +: OUT_W] = a_ext + b_ext;
  end

  // Data is not gated by valid: bubbles shift through like real beats.
  always_comb begin
    vec_d = vec_q;
    vld_d = vld_q;
    if (adv) begin
      vec_d = sum_w;
      vld_d = in_vld;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vec_q <= vec_d;
      vld_q <= vld_d;
    end
  end

  assign out_vec = vec_q;
  assign out_vld = vld_q;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined full-precision adder tree with a global stall; ADDER_TREE_SAT_EN adds
// an output clamp to the DATA_W range plus the sat_out flag.
module pipelined_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 4,
  parameter int SIGNED = 1
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_adder_tree_if.slave bus
);

  localparam int LVLS  = calc_lvls(NUM_IN);
  localparam int OUT_W = calc_out_w(DATA_W, NUM_IN);
  localparam int FIN_W = DATA_W + LVLS;

  logic             adv;
  logic [FIN_W-1:0] fin_vec;
  logic             fin_vld;

  // Whole pipeline moves in lockstep; only the output register can stall it.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar n = 1; n <= LVLS; n++) begin : g_lvl
    localparam int IW = DATA_W + n - 1;
    localparam int IC = elem_cnt(NUM_IN, n - 1);
    localparam int OC = elem_cnt(NUM_IN, n);

    logic [IC*IW-1:0]     vin;
    logic                 vin_vld;
    logic [OC*(IW+1)-1:0] vec;
    logic                 vld;

    if (n == 1) begin : g_src
      assign vin     = bus.data_in;
      assign vin_vld = bus.in_valid;
    end else begin : g_chain
      assign vin     = g_lvl[n-1].vec;
      assign vin_vld = g_lvl[n-1].vld;
    end

    adder_tree_level #(
      .IN_W   (IW),
      .IN_CNT (IC),
      .SIGNED (SIGNED)
    ) u_level (
      .clk     (clk),
      .rst     (rst),
      .adv     (adv),
      .in_vld  (vin_vld),
      .in_vec  (vin),
      .out_vld (vld),
      .out_vec (vec)
    );

    if (n == LVLS) begin : g_last
      assign fin_vec = vec;
      assign fin_vld = vld;
    end
  end

  assign bus.out_valid = fin_vld;

`ifdef ADDER_TREE_SAT_EN
  localparam logic [FIN_W-1:0] SMAX = {{(FIN_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [FIN_W-1:0] SMIN = {{(FIN_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [FIN_W-1:0] UMAX = {{(FIN_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  logic [FIN_W-1:0] clamped;
  logic             clip;

  // Clamp is combinational after the final register, so latency is unchanged
  // and the held output stays stable during a stall.
  always_comb begin
    clamped = fin_vec;
    clip    = 1'b0;
    if (SIGNED != 0) begin
      if ($signed(fin_vec) > $signed(SMAX)) begin
        clamped = SMAX;
        clip    = 1'b1;
      end else if ($signed(fin_vec) < $signed(SMIN)) begin
        clamped = SMIN;
        clip    = 1'b1;
      end
    end else if (fin_vec > UMAX) begin
      clamped = UMAX;
      clip    = 1'b1;
    end
  end

  assign bus.data_out = clamped[OUT_W-1:0];
  assign bus.sat_out  = fin_vld && clip;
`else
  assign bus.data_out = fin_vec[OUT_W-1:0];
`endif

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Bench for pipelined_adder_tree: four instances (signed x4, unsigned x4,
// signed x5, signed x1) sharing one clock, with a per-instance expected queue.
module tb_pipelined_adder_tree;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [16:0] exp_q [4][$];

  pipelined_adder_tree_if #(.DATA_W(8), .NUM_IN(4)) bus_s4 ();
  pipelined_adder_tree_if #(.DATA_W(8), .NUM_IN(4)) bus_u4 ();
  pipelined_adder_tree_if #(.DATA_W(8), .NUM_IN(5)) bus_s5 ();
  pipelined_adder_tree_if #(.DATA_W(8), .NUM_IN(1)) bus_s1 ();

  pipelined_adder_tree #(.DATA_W(8), .NUM_IN(4), .SIGNED(1)) dut_s4 (.clk(clk), .rst(rst), .bus(bus_s4));
  pipelined_adder_tree #(.DATA_W(8), .NUM_IN(4), .SIGNED(0)) dut_u4 (.clk(clk), .rst(rst), .bus(bus_u4));
  pipelined_adder_tree #(.DATA_W(8), .NUM_IN(5), .SIGNED(1)) dut_s5 (.clk(clk), .rst(rst), .bus(bus_s5));
  pipelined_adder_tree #(.DATA_W(8), .NUM_IN(1), .SIGNED(1)) dut_s1 (.clk(clk), .rst(rst), .bus(bus_s1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [39:0] lanes;
    int          exp;
  } tv_t;

  function automatic bit sgn_of(input int id);
    return id != 1;
  endfunction

  function automatic int nlanes_of(input int id);
    case (id)
      2:       return 5;
      3:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int w_of(input int id);
    case (id)
      2:       return 11;
      3:       return 8;
      default: return 10;
    endcase
  endfunction

  function automatic int lvls_of(input int id);
    case (id)
      2:       return 3;
      3:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic bit ready_of(input int id);
    case (id)
      0:       return bus_s4.in_ready;
      1:       return bus_u4.in_ready;
      2:       return bus_s5.in_ready;
      default: return bus_s1.in_ready;
    endcase
  endfunction

  function automatic bit valid_of(input int id);
    case (id)
      0:       return bus_s4.out_valid;
      1:       return bus_u4.out_valid;
      2:       return bus_s5.out_valid;
      default: return bus_s1.out_valid;
    endcase
  endfunction

  function automatic bit oready_of(input int id);
    case (id)
      0:       return bus_s4.out_ready;
      1:       return bus_u4.out_ready;
      2:       return bus_s5.out_ready;
      default: return bus_s1.out_ready;
    endcase
  endfunction

  function automatic logic [15:0] dout_of(input int id);
    case (id)
      0:       return 16'(bus_s4.data_out);
      1:       return 16'(bus_u4.data_out);
      2:       return 16'(bus_s5.data_out);
      default: return 16'(bus_s1.data_out);
    endcase
  endfunction

  function automatic bit sat_of(input int id);
`ifdef ADDER_TREE_SAT_EN
    case (id)
      0:       return bus_s4.sat_out;
      1:       return bus_u4.sat_out;
      2:       return bus_s5.sat_out;
      default: return bus_s1.sat_out;
    endcase
`else
    return (id < 0);
`endif
  endfunction

  // Reference clamp: identity unless the saturating build is selected.
  function automatic logic [16:0] clamp_exp(input int v, input bit sgn);
    logic sat;
    int   r;
    sat = 1'b0;
    r   = v;
`ifdef ADDER_TREE_SAT_EN
    if (sgn) begin
      if (v > 127) begin r = 127; sat = 1'b1; end
      else if (v < -128) begin r = -128; sat = 1'b1; end
    end else if (v > 255) begin
      r = 255;
      sat = 1'b1;
    end
`else
    if (sgn && v == 32'h7fffffff) sat = 1'b0;
`endif
    return {sat, r[15:0]};
  endfunction

  function automatic logic [16:0] model(input logic [39:0] lanes, input int n, input bit sgn);
    int sum;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      if (sgn) sum += int'($signed(lanes[i*8 +: 8]));
      else     sum += int'(lanes[i*8 +: 8]);
    end
    return clamp_exp(sum, sgn);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic checkOutput(input int id);
    logic [16:0] e;
    logic [15:0] mask;
    total++;
    if (exp_q[id].size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_output dut%0d: got %0h expected none", id, dout_of(id));
      return;
    end
    e    = exp_q[id].pop_front();
    mask = 16'((32'd1 << w_of(id)) - 1);
    if ((dout_of(id) & mask) !== (e[15:0] & mask)) begin
      bad++;
      $display("[TB] FAIL sum dut%0d: got %0h expected %0h", id, dout_of(id) & mask, e[15:0] & mask);
    end
`ifdef ADDER_TREE_SAT_EN
    check($sformatf("sat dut%0d", id), 32'(sat_of(id)), 32'(e[16]));
`endif
  endtask

  task automatic drive(input int id, input bit v, input logic [39:0] lanes);
    case (id)
      0: begin bus_s4.in_valid = v; bus_s4.data_in = lanes[31:0]; end
      1: begin bus_u4.in_valid = v; bus_u4.data_in = lanes[31:0]; end
      2: begin bus_s5.in_valid = v; bus_s5.data_in = lanes[39:0]; end
      default: begin bus_s1.in_valid = v; bus_s1.data_in = lanes[7:0]; end
    endcase
  endtask

  task automatic idle_all();
    @(negedge clk);
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 40'd0);
  endtask

  // Drives one vector and holds it until accepted; expectation queued on acceptance.
  task automatic applyStimulus(input int id, input logic [39:0] lanes, input logic [16:0] e);
    int guard;
    guard = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 40'd0);
    drive(id, 1'b1, lanes);
    #1;
    while (!ready_of(id) && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (ready_of(id)) exp_q[id].push_back(e);
    else begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout dut%0d: got in_ready=0 expected 1", id);
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("drain", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 32'd0);
  endtask

  task automatic latency_test(input int id, input logic [39:0] lanes, input int exp);
    int n;
    n = 0;
    applyStimulus(id, lanes, clamp_exp(exp, sgn_of(id)));
    while (n < 10) begin
      idle_all();
      #3;
      n++;
      check($sformatf("in_ready dut%0d", id), 32'(ready_of(id)), 32'd1);
      if (valid_of(id)) break;
    end
    check($sformatf("latency dut%0d", id), 32'(n), 32'(lvls_of(id)));
  endtask

  always begin
    @(negedge clk);
    #2;
    for (int i = 0; i < 4; i++)
      if (valid_of(i) && oready_of(i)) checkOutput(i);
  end

  initial begin
    tv_t         tv [12];
    logic [39:0] r;
    logic [15:0] held;

    tv[0]  = '{0, {8'd0, 8'd4, 8'd3, 8'd2, 8'd1}, 10};
    tv[1]  = '{0, {8'd0, 8'h80, 8'h80, 8'h80, 8'h80}, -512};
    tv[2]  = '{0, {8'd0, 8'h7f, 8'h7f, 8'h7f, 8'h7f}, 508};
    tv[3]  = '{1, {8'd0, 8'hff, 8'hff, 8'hff, 8'hff}, 1020};
    tv[4]  = '{2, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 15};
    tv[5]  = '{3, {32'd0, 8'hf9}, -7};
    tv[6]  = '{0, {8'd0, 8'd0, 8'd0, 8'd100, 8'd100}, 200};
    tv[7]  = '{0, {8'd0, 8'd0, 8'd0, 8'h9c, 8'h9c}, -200};
    tv[8]  = '{0, {8'd0, 8'hff, 8'd5, 8'hfd, 8'd2}, 3};
    tv[9]  = '{1, {8'd0, 8'd3, 8'd2, 8'd1, 8'd200}, 206};
    tv[10] = '{2, {8'h80, 8'h80, 8'h80, 8'h80, 8'h80}, -640};
    tv[11] = '{1, 40'd0, 0};

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 40'd0);
    bus_s4.out_ready = 1'b1;
    bus_u4.out_ready = 1'b1;
    bus_s5.out_ready = 1'b1;
    bus_s1.out_ready = 1'b1;
    #3;
    check("rst out_valid", 32'(bus_s4.out_valid), 32'd0);
    check("rst data_out", 32'(bus_s4.data_out), 32'd0);
    check("rst in_ready", 32'(bus_s4.in_ready), 32'd1);
    check("rst out_valid s5", 32'(bus_s5.out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] latency");
    latency_test(0, {8'd0, 8'd4, 8'd3, 8'd2, 8'd1}, 10);
    latency_test(2, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 15);
    latency_test(3, {32'd0, 8'hf9}, -7);
    wait_drain();

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++)
      applyStimulus(tv[i].id, tv[i].lanes, clamp_exp(tv[i].exp, sgn_of(tv[i].id)));
    for (int i = 0; i < 6; i++) begin
      r = {$urandom, $urandom};
      applyStimulus(i % 3, r, model(r, nlanes_of(i % 3), sgn_of(i % 3)));
    end
    idle_all();
    wait_drain();

    $display("[TB] backpressure");
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          r = {$urandom, $urandom};
          applyStimulus(0, r, model(r, 4, 1'b1));
        end
        idle_all();
      end
      begin
        repeat (3) @(negedge clk);
        bus_s4.out_ready = 1'b0;
        #3;
        held = dout_of(0);
        for (int k = 0; k < 3; k++) begin
          check("stall in_ready", 32'(bus_s4.in_ready), 32'd0);
          check("stall out_valid", 32'(bus_s4.out_valid), 32'd1);
          check("stall data_out", 32'(dout_of(0)), 32'(held));
          @(negedge clk);
          if (k < 2) #3;
        end
        bus_s4.out_ready = 1'b1;
        #3;
        check("resume in_ready", 32'(bus_s4.in_ready), 32'd1);
      end
    join
    wait_drain();

    $display("[TB] reset mid-flight");
    applyStimulus(0, {8'd0, 8'd1, 8'd1, 8'd1, 8'd1}, clamp_exp(4, 1'b1));
    applyStimulus(0, {8'd0, 8'd2, 8'd2, 8'd2, 8'd2}, clamp_exp(8, 1'b1));
    idle_all();
    #3;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    #1;
    check("async rst out_valid", 32'(bus_s4.out_valid), 32'd0);
    check("async rst data_out", 32'(bus_s4.data_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #3;
      check("post-rst out_valid", 32'(bus_s4.out_valid), 32'd0);
    end
    applyStimulus(0, {8'd0, 8'd4, 8'd3, 8'd2, 8'd1}, clamp_exp(10, 1'b1));
    idle_all();
    wait_drain();

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
